man_squeeze_gen: RTL and testbench

//  Parametrised squeeze/charge generator for the jumping man. Counts charge while the game FSM is in ACCU,

---
 rtl/man_squeeze_gen.sv | 129 ++++++++++++
 tb/tb_man_squeeze_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/man_squeeze_gen.sv
// man_squeeze_gen: charge/squeeze generator for the jumping man.
// Counts charge while the game sits in the charging state and saturates at CNT_MAX.
// On release it latches the charge for the jump distance, then winds the squeeze
// back down to zero in RECOVER_STEP decrements (the rebound).
// All stepping uses a clock-enable tick from a prescaler. There are no derived clocks.
module man_squeeze_gen #(
  parameter int                   STATE_W      = 3,
  parameter logic [STATE_W-1:0]   ACCU_CODE    = STATE_W'(3),
  parameter int                   PRESCALE_W   = 20,
  parameter int                   CNT_W        = 4,
  parameter int                   CNT_MAX      = 15,
  parameter int                   OUT_SHIFT    = 1,
  parameter int                   RECOVER_STEP = 2
) (
  input  logic                       clk_machine,
  input  logic                       rst_machine,
  input  logic [STATE_W-1:0]         state,
  input  logic                       freeze,
  output logic [CNT_W-OUT_SHIFT-1:0] o_squeeze_man,
  output logic                       o_full,
  output logic                       o_release_pulse,
  output logic [CNT_W-1:0]           o_charge_latched,
  output logic [1:0]                 o_fsm
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHARGE  = 2'd1,
    FULL    = 2'd2,
    RECOVER = 2'd3
  } fsm_e;

  localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] STEP_V    = CNT_W'(RECOVER_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  fsm_e                  fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  pulse_q, pulse_d;
  logic [CNT_W-1:0]      latched_q, latched_d;
  logic                  accu;
  logic                  tick;
  logic                  release_ev;

  assign accu = (state == ACCU_CODE);
  assign tick = (&presc_q) && !freeze;

  // Next-state logic for the FSM, the charge counter, the prescaler and the release outputs.
  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    latched_d  = latched_q;
    release_ev = 1'b0;
    presc_d    = freeze ? presc_q : presc_q + PRESCALE_W'(1);

    case (fsm_q)
      IDLE: begin
        cnt_d = '0;
        if (accu) fsm_d = CHARGE;
      end
      CHARGE: begin
        if (!accu) begin
          release_ev = 1'b1;
        end else if (tick) begin
          if (cnt_q >= CNT_MAX_V - CNT_ONE) begin
            cnt_d = CNT_MAX_V;
            fsm_d = FULL;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      FULL: begin
        cnt_d = CNT_MAX_V;
        if (!accu) release_ev = 1'b1;
      end
      RECOVER: begin
        if (accu) begin
          fsm_d = CHARGE;
        end else if (tick) begin
          if (cnt_q > STEP_V) begin
            cnt_d = cnt_q - STEP_V;
          end else begin
            cnt_d = '0;
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase

    // A release takes priority over any coincident tick and keeps the pre-tick count.
    if (release_ev) begin
      cnt_d     = cnt_q;
      latched_d = cnt_q;
      pulse_d   = 1'b1;
      fsm_d     = (cnt_q != '0) ? RECOVER : IDLE;
    end

    // Restarting the prescaler on entry makes the first step land a full period later.
    if ((fsm_d == CHARGE) && (fsm_q != CHARGE)) presc_d = '0;
  end

  // State and output registers. Reset asynchronously to all-zero.
  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      fsm_q     <= IDLE;
      cnt_q     <= '0;
      presc_q   <= '0;
      pulse_q   <= 1'b0;
      latched_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      pulse_q   <= pulse_d;
      latched_q <= latched_d;
    end
  end

  assign o_squeeze_man    = (CNT_W-OUT_SHIFT)'(cnt_q >> OUT_SHIFT);
  assign o_full           = (fsm_q == FULL);
  assign o_release_pulse  = pulse_q;
  assign o_charge_latched = latched_q;
  assign o_fsm            = fsm_q;

endmodule

// File: tb/tb_man_squeeze_gen.sv
// Testbench for man_squeeze_gen using a short prescaler (one step every 4 cycles).
// Directed vector tables hold hand-computed expected outputs. A few hand-written
// sequences cover the asynchronous reset and its release.
module tb_man_squeeze_gen;

  logic       clk_machine;
  logic       rst_machine;
  logic [2:0] state;
  logic       freeze;
  logic [2:0] o_squeeze_man;
  logic       o_full;
  logic       o_release_pulse;
  logic [3:0] o_charge_latched;
  logic [1:0] o_fsm;

  int checks;
  int passes;

  typedef struct {
    int st;
    int frz;
    int n;
    int sq;
    int full;
    int fsm;
    int pulse;
    int lat;
  } vec_t;

  vec_t vecs[$];

  man_squeeze_gen #(
    .STATE_W(3), .ACCU_CODE(3'd3), .PRESCALE_W(2), .CNT_W(4),
    .CNT_MAX(15), .OUT_SHIFT(1), .RECOVER_STEP(2)
  ) dut (
    .clk_machine     (clk_machine),
    .rst_machine     (rst_machine),
    .state           (state),
    .freeze          (freeze),
    .o_squeeze_man   (o_squeeze_man),
    .o_full          (o_full),
    .o_release_pulse (o_release_pulse),
    .o_charge_latched(o_charge_latched),
    .o_fsm           (o_fsm)
  );

  // 100 MHz-style bench clock.
  initial clk_machine = 1'b0;
  always #5 clk_machine = ~clk_machine;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic checkOutput(input string tag, input int sq, input int full,
                             input int fsm, input int pulse, input int lat);
    cmp({tag, ".squeeze"}, int'(o_squeeze_man), sq);
    cmp({tag, ".full"},    int'(o_full), full);
    cmp({tag, ".fsm"},     int'(o_fsm), fsm);
    cmp({tag, ".pulse"},   int'(o_release_pulse), pulse);
    cmp({tag, ".latched"}, int'(o_charge_latched), lat);
  endtask

  // Drive inputs, then advance n clocks and land 1 ns after the last edge.
  task automatic applyStimulus(input int st, input int frz, input int n);
    state  = 3'(st);
    freeze = frz[0];
    repeat (n) begin
      @(posedge clk_machine);
      #1;
    end
  endtask

  task automatic add(input int st, input int frz, input int n, input int sq,
                     input int full, input int fsm, input int pulse, input int lat);
    vec_t v;
    v.st = st; v.frz = frz; v.n = n; v.sq = sq;
    v.full = full; v.fsm = fsm; v.pulse = pulse; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic runTable(input string name);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, vecs[i].frz, vecs[i].n);
      checkOutput($sformatf("%s[%0d]", name, i), vecs[i].sq, vecs[i].full,
                  vecs[i].fsm, vecs[i].pulse, vecs[i].lat);
    end
    vecs.delete();
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    rst_machine = 1'b0;
    state       = 3'd0;
    freeze      = 1'b0;

    applyStimulus(0, 0, 3);
    checkOutput("reset", 0, 0, 0, 0, 0);
    rst_machine = 1'b1;

    // Full charge to saturation, hold, release from FULL, decay to IDLE.
    add(3,0,1,  0,0,1,0,0);
    add(3,0,3,  0,0,1,0,0);
    add(3,0,1,  0,0,1,0,0);
    add(3,0,4,  1,0,1,0,0);
    add(3,0,51, 7,0,1,0,0);
    add(3,0,1,  7,1,2,0,0);
    add(3,0,3,  7,1,2,0,0);
    add(0,0,1,  7,0,3,1,15);
    add(0,0,1,  7,0,3,0,15);
    add(0,0,3,  6,0,3,0,15);
    add(0,0,4,  5,0,3,0,15);
    add(0,0,20, 0,0,3,0,15);
    add(0,0,4,  0,0,0,0,15);
    // Release at 9: decay 7,5,3,1,0.
    add(3,0,1,  0,0,1,0,15);
    add(3,0,36, 4,0,1,0,15);
    add(0,0,1,  4,0,3,1,9);
    add(0,0,1,  4,0,3,0,9);
    add(0,0,2,  3,0,3,0,9);
    add(0,0,4,  2,0,3,0,9);
    add(0,0,4,  1,0,3,0,9);
    add(0,0,4,  0,0,3,0,9);
    add(0,0,4,  0,0,0,0,9);
    // Re-charge from RECOVER at 5: prescaler restarts, 6 exactly 4 cycles later.
    add(3,0,1,  0,0,1,0,9);
    add(3,0,28, 3,0,1,0,9);
    add(3,0,1,  3,0,1,0,9);
    add(0,0,1,  3,0,3,1,7);
    add(0,0,2,  2,0,3,0,7);
    add(3,0,1,  2,0,1,0,7);
    add(3,0,3,  2,0,1,0,7);
    add(3,0,1,  3,0,1,0,7);
    runTable("seqA");

    // Asynchronous reset mid-charge, with accu still held.
    #2;
    rst_machine = 1'b0;
    #1;
    checkOutput("rst_async", 0, 0, 0, 0, 0);
    applyStimulus(3, 0, 3);
    checkOutput("rst_hold", 0, 0, 0, 0, 0);
    rst_machine = 1'b1;
    #1;
    checkOutput("rst_release", 0, 0, 0, 0, 0);

    // Freeze at 4, release while frozen, then thaw and decay.
    add(3,0,1,  0,0,1,0,0);
    add(3,0,16, 2,0,1,0,0);
    add(3,0,1,  2,0,1,0,0);
    add(3,1,10, 2,0,1,0,0);
    add(0,1,1,  2,0,3,1,4);
    add(0,1,7,  2,0,3,0,4);
    add(0,0,2,  2,0,3,0,4);
    add(0,0,1,  1,0,3,0,4);
    add(0,0,4,  0,0,0,0,4);
    // Release on the tick edge at 4: latched stays 4, next RECOVER tick gives 2.
    add(3,0,1,  0,0,1,0,4);
    add(3,0,16, 2,0,1,0,4);
    add(3,0,3,  2,0,1,0,4);
    add(0,0,1,  2,0,3,1,4);
    add(0,0,3,  2,0,3,0,4);
    add(0,0,1,  1,0,3,0,4);
    add(0,0,4,  0,0,0,0,4);
    runTable("seqB");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
